// File: rtl/rst_pkg.sv
// Shared definitions for the register-reset sequencer: command codes,
// FSM state encoding and register index names.
package rst_pkg;

    localparam int RST_NONE = 0;

    localparam int IDX_ART  = 0;
    localparam int IDX_ARG  = 1;
    localparam int IDX_AWT  = 2;
    localparam int IDX_AWG  = 3;
    localparam int IDX_MDAR = 4;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        NEXT,
        FIN
    } rst_state_t;

    function automatic int rst_all_par(input int n_reg);
        return n_reg + 1;
    endfunction

    function automatic int rst_all_seq(input int n_reg);
        return n_reg + 2;
    endfunction

endpackage

// File: rtl/rst_code_decode.sv
// Combinational command decoder: turns a select code into the initial
// strobe mask plus sequential / illegal / active flags.
module rst_code_decode
    import rst_pkg::*;
#(
    parameter int N_REG = 5,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0] sel,
    output logic [N_REG-1:0] mask,
    output logic             seq,
    output logic             illegal,
    output logic             go
);

    int unsigned code;

    assign code = 32'(sel);

    always_comb begin
        mask    = '0;
        seq     = 1'b0;
        illegal = 1'b0;
        go      = 1'b0;
        if (code == RST_NONE) begin
            go = 1'b0;
        end else if (code <= N_REG) begin
            for (int i = 0; i < N_REG; i++) begin
                if (code == i + 1) mask[i] = 1'b1;
            end
            go = 1'b1;
        end else if (code == rst_all_par(N_REG)) begin
            mask = '1;
            go   = 1'b1;
        end else if (code == rst_all_seq(N_REG)) begin
            // sequential mode starts at register 0 and walks left
            mask = {{(N_REG-1){1'b0}}, 1'b1};
            seq  = 1'b1;
            go   = 1'b1;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Register-reset sequencer: accepts a reset command and drives registered,
// non-overlapping clear strobes with busy/done/err handshaking.
module rst_sequencer
    import rst_pkg::*;
#(
    parameter int N_REG     = 5,
    parameter int PULSE_LEN = 1,
    parameter int SEL_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] sel,
    output logic [N_REG-1:0] clr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);
    localparam int IDX_W = $clog2(N_REG + 1);

    logic [N_REG-1:0] dec_mask;
    logic             dec_seq;
    logic             dec_illegal;
    logic             dec_go;

    rst_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [N_REG-1:0] mask_q;
    logic             seq_q;

    rst_code_decode #(
        .N_REG (N_REG),
        .SEL_W (SEL_W)
    ) u_decode (
        .sel     (sel),
        .mask    (dec_mask),
        .seq     (dec_seq),
        .illegal (dec_illegal),
        .go      (dec_go)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            clr    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
            mask_q <= '0;
            seq_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q <= dec_mask;
                        seq_q  <= dec_seq;
                        idx    <= '0;
                        cnt    <= CNT_W'(PULSE_LEN);
                        busy   <= 1'b1;
                        if (dec_go) begin
                            clr   <= dec_mask;
                            state <= PULSE;
                        end else begin
                            done  <= 1'b1;
                            err   <= dec_illegal;
                            state <= FIN;
                        end
                    end
                end
                PULSE: begin
                    if (cnt == CNT_W'(1)) begin
                        clr <= '0;
                        if (seq_q && (idx < IDX_W'(N_REG - 1))) begin
                            state <= NEXT;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                NEXT: begin
                    // one dead cycle between strobes, then move to the next register
                    idx    <= idx + 1'b1;
                    mask_q <= mask_q << 1;
                    clr    <= mask_q << 1;
                    cnt    <= CNT_W'(PULSE_LEN);
                    state  <= PULSE;
                end
                FIN: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed vector table, multi-cycle
// corner sequences and randomized commands against a trace-based model.
module tb_rst_sequencer;

    localparam int N  = 5;
    localparam int PL = 2;
    localparam int SW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] sel   = '0;
    logic [N-1:0]  clr;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    rst_sequencer #(
        .N_REG     (N),
        .PULSE_LEN (PL),
        .SEL_W     (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sel   (sel),
        .clr   (clr),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    typedef struct packed {
        logic [N-1:0] clr;
        logic         busy;
        logic         done;
        logic         err;
    } out_t;

    typedef struct {
        logic          r;
        logic          s;
        logic [SW-1:0] sl;
        out_t          want;
        string         name;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vt[$];
    out_t mq[$];
    out_t cur;

    function automatic out_t mk(input logic [N-1:0] c, input logic b,
                                input logic d, input logic e);
        out_t o;
        o.clr  = c;
        o.busy = b;
        o.done = d;
        o.err  = e;
        return o;
    endfunction

    task automatic add(input logic r, input logic s, input logic [SW-1:0] sl,
                       input out_t want, input string name);
        vec_t v;
        v.r = r; v.s = s; v.sl = sl; v.want = want; v.name = name;
        vt.push_back(v);
    endtask

    task automatic step(input logic r, input logic s, input logic [SW-1:0] sl,
                        input out_t want, input string name);
        out_t got;
        @(negedge clk);
        rst_n = r;
        start = s;
        sel   = sl;
        @(posedge clk);
        #1;
        got = mk(clr, busy, done, err);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got clr=%b busy=%b done=%b err=%b, expected clr=%b busy=%b done=%b err=%b",
                     name, $time, got.clr, got.busy, got.done, got.err,
                     want.clr, want.busy, want.done, want.err);
        end
    endtask

    // Expected per-cycle outputs following an accepted command code c.
    task automatic push_trace(input int c);
        logic [N-1:0] one;
        one = 1;
        if (c >= 1 && c <= N) begin
            repeat (PL) mq.push_back(mk(one << (c - 1), 1'b1, 1'b0, 1'b0));
        end else if (c == N + 1) begin
            repeat (PL) mq.push_back(mk('1, 1'b1, 1'b0, 1'b0));
        end else if (c == N + 2) begin
            for (int k = 0; k < N; k++) begin
                repeat (PL) mq.push_back(mk(one << k, 1'b1, 1'b0, 1'b0));
                if (k < N - 1) mq.push_back(mk('0, 1'b1, 1'b0, 1'b0));
            end
        end
        mq.push_back(mk('0, 1'b1, 1'b1, (c > N + 2)));
    endtask

    task automatic model_edge(input logic r, input logic s, input logic [SW-1:0] sl);
        if (!r) begin
            mq.delete();
            cur = '0;
        end else begin
            if (s && !cur.busy && mq.size() == 0) push_trace(int'(sl));
            cur = (mq.size() > 0) ? mq.pop_front() : out_t'(0);
        end
    endtask

    out_t          z;
    out_t          e;
    logic [N-1:0]  one;
    logic          rr;
    logic          ss;
    logic [SW-1:0] ssl;

    initial begin
        z   = '0;
        one = 1;
        cur = '0;

        // reset held with a pending command, then release
        repeat (3) add(0, 1, 6, z, "reset_hold");
        add(1, 0, 0, z, "reset_release");
        // single clear of AWT
        add(1, 1, 3, mk(5'b00100, 1, 0, 0), "single_c1");
        add(1, 0, 0, mk(5'b00100, 1, 0, 0), "single_c2");
        add(1, 0, 0, mk(5'b00000, 1, 1, 0), "single_done");
        add(1, 0, 0, z, "single_idle");
        // ALL_PAR with starts hammered while busy
        add(1, 1, 6, mk(5'b11111, 1, 0, 0), "par_c1");
        add(1, 1, 1, mk(5'b11111, 1, 0, 0), "par_c2");
        add(1, 1, 1, mk(5'b00000, 1, 1, 0), "par_done");
        add(1, 1, 1, z, "par_fin_ignored");
        add(1, 1, 1, mk(5'b00001, 1, 0, 0), "par_next_accept");
        add(1, 0, 0, mk(5'b00001, 1, 0, 0), "par_next_c2");
        add(1, 0, 0, mk(5'b00000, 1, 1, 0), "par_next_done");
        add(1, 0, 0, z, "par_next_idle");
        // NONE and illegal codes
        add(1, 1, 0, mk(5'b00000, 1, 1, 0), "none_done");
        add(1, 0, 0, z, "none_idle");
        add(1, 1, 8, mk(5'b00000, 1, 1, 1), "illegal8_done");
        add(1, 0, 0, z, "illegal8_idle");
        add(1, 1, 15, mk(5'b00000, 1, 1, 1), "illegal15_done");
        add(1, 1, 15, z, "illegal15_fin_ignored");
        add(1, 0, 0, z, "illegal15_idle");

        for (int i = 0; i < vt.size(); i++)
            step(vt[i].r, vt[i].s, vt[i].sl, vt[i].want, vt[i].name);

        // ALL_SEQ full walk: PL-cycle strobes separated by one-cycle gaps
        for (int k = 1; k <= N * (PL + 1); k++) begin
            if (k == N * (PL + 1)) e = mk('0, 1, 1, 0);
            else if ((k - 1) % (PL + 1) < PL) e = mk(one << ((k - 1) / (PL + 1)), 1, 0, 0);
            else e = mk('0, 1, 0, 0);
            step(1, (k == 1), 7, e, "allseq");
        end
        step(1, 0, 0, z, "allseq_idle");

        // reset in the middle of ALL_SEQ
        for (int k = 1; k <= 4; k++) begin
            if ((k - 1) % (PL + 1) < PL) e = mk(one << ((k - 1) / (PL + 1)), 1, 0, 0);
            else e = mk('0, 1, 0, 0);
            step(1, (k == 1), 7, e, "midrst_pre");
        end
        step(0, 0, 0, z, "midrst_abort");
        step(0, 0, 0, z, "midrst_hold");
        repeat (4) step(1, 0, 0, z, "midrst_no_done");
        step(1, 1, 2, mk(5'b00010, 1, 0, 0), "midrst_new_cmd");
        step(1, 0, 0, mk(5'b00010, 1, 0, 0), "midrst_new_c2");
        step(1, 0, 0, mk(5'b00000, 1, 1, 0), "midrst_new_done");

        // randomized commands against the trace model
        model_edge(0, 0, 0);
        step(0, 0, 0, cur, "random_reset");
        for (int i = 0; i < 3000; i++) begin
            rr  = ($urandom_range(0, 59) != 0);
            ss  = $urandom_range(0, 1) == 1;
            ssl = SW'($urandom_range(0, 15));
            model_edge(rr, ss, ssl);
            step(rr, ss, ssl, cur, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised successor to the processor's register-reset decoder. It accepts a reset command (select code plus start strobe) from the control unit. It drives per-register clear strobes to the address and data registers (ART, ARG, AWT, AWG, MDAR in the default build) for a programmable number of cycles. It adds a staggered "clear-all" mode, busy/done handshaking and illegal-code reporting.

## Interface
- `N_REG`, default 5: number of clearable registers and clear strobes; 1–30.
- `PULSE_LEN`, default 1: cycles each clear strobe is held high; 1–15.
- `SEL_W`, default 3: select width; must satisfy 2^SEL_W ≥ N_REG+3.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: command strobe; sampled only in IDLE.
- `sel`, in, SEL_W: command code, sampled with `start`.
- `clr`, out, N_REG: clear strobes; bit i is register i (0=ART, 1=ARG, 2=AWT, 3=AWG, 4=MDAR).
- `busy`, out, 1: a command is in progress; new `start` is ignored.
- `done`, out, 1: one-cycle pulse when a command completes.
- `err`, out, 1: one-cycle pulse coincident with `done` for an illegal code.

## Operation
- Codes:
  - 0 = NONE.
  - 1..N_REG = clear register sel-1 only.
  - N_REG+1 = ALL_PAR: every `clr` bit high together.
  - N_REG+2 = ALL_SEQ: bits 0..N_REG-1 in turn, one at a time.
  - Any other value = illegal.
- FSM states: IDLE, PULSE, NEXT, FIN.
- IDLE, `start`=1:
  - latch `sel`;
  - go to PULSE for a single-register, ALL_PAR or ALL_SEQ code;
  - go to FIN for NONE or an illegal code.
- PULSE:
  - drive the latched strobe mask for PULSE_LEN cycles, using a down-counter of width clog2(PULSE_LEN+1);
  - on expiry, go to NEXT for ALL_SEQ when the index is below N_REG-1, otherwise go to FIN.
- NEXT: one cycle with `clr`=0; increment the index; return to PULSE. This gap guarantees non-overlapping strobes.
- FIN:
  - `done`=1 for one cycle;
  - `err`=1 if the latched code was illegal;
  - `clr`=0;
  - return to IDLE.
- `busy` is 1 in PULSE, NEXT and FIN, and 0 in IDLE.
- `start` outside IDLE is ignored: it is neither queued nor counted.
- `start` during the FIN cycle is also ignored. A new command is accepted on the cycle after `done`.
- `clr` is a registered output and is glitch-free. At most one bit is high in ALL_SEQ.
- The strobe mask is decoded once at acceptance into an N_REG-bit register.
  - ALL_SEQ uses a one-hot mask that shifts left one position per NEXT.

## Timing
- Reset (`rst_n`=0 at a clock edge): state=IDLE; `clr`=0, `busy`=0, `done`=0, `err`=0; counter and index cleared. This holds mid-command: strobes drop on the next edge, and no `done` is produced for the aborted command.
- Accepting edge t (IDLE, `start`=1): `clr` is high on cycles t+1 .. t+PULSE_LEN; `done` is high at t+PULSE_LEN+1.
- ALL_SEQ latency: `done` at t + N_REG·(PULSE_LEN+1).
- NONE or illegal code: `done` (with `err` if illegal) at t+1; no `clr` activity.
- Throughput: back-to-back commands need one idle cycle after `done`.
- `sel` is don't-care except at acceptance.

## Structure
- Shared package `rst_pkg`:
  - code constants RST_NONE=0, RST_ALL_PAR(N), RST_ALL_SEQ(N);
  - state enum {IDLE, PULSE, NEXT, FIN};
  - register-index constants IDX_ART..IDX_MDAR.
- Sub-module `rst_code_decode` is natural: combinational sel→{mask, seq, illegal}, parametrised by N_REG.
- The top holds the FSM, pulse counter, index and output registers.

## Test plan
All scenarios use N_REG=5, PULSE_LEN=2.
- Reset: hold `rst_n`=0 for 3 cycles with `start`=1, `sel`=6 → all outputs stay 0 throughout and on the first cycle after release.
- Single clear: `sel`=3, `start` at edge t → `clr`=5'b00100 at t+1 and t+2; `done` at t+3; `busy` at t+1..t+3; `err`=0.
- ALL_SEQ: `sel`=7 at t → `clr`=00001 at t+1..t+2, 0 at t+3, 00010 at t+4..t+5, and so on through 10000 at t+13..t+14; `done` at t+15.
- ALL_PAR followed by `start`, `sel`=1 on every busy cycle → `clr`=11111 for 2 cycles; `done` at t+3; no further `clr` activity from the ignored starts. A `start` at t+4 is accepted.
- Illegal and NONE: `sel`=0 → `done` at t+1 with `err`=0. `sel`=8 with SEL_W=4 → `done`=`err`=1 at t+1. `clr` stays 0 in both cases.
- Reset mid-ALL_SEQ: `rst_n`=0 at t+5 → `clr`=0 from t+6 onward; no `done`; a new command is accepted after release.
